// File: rtl/jk_bank_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_pkg
//  Description : Shared definitions for the JK bank sequencer: op encodings,
//                sequencer state type and the op -> {J,K} decode.
//  Revision    : 1.0  initial release
// ============================================================================
package jk_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_CLR    = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_DRIVE  = 2'd2,
    ST_SAMPLE = 2'd3
  } state_t;

  // Returns {J,K} for one flop.
  function automatic logic [1:0] op_to_jk(input logic [1:0] op);
    logic [1:0] jk;
    jk = 2'b00;
    case (op)
      OP_HOLD:   jk = 2'b00;
      OP_CLR:    jk = 2'b01;
      OP_SET:    jk = 2'b10;
      OP_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_bank_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches req upward from
//                ptr with wrap-around and grants the first set bit.
//  Ports       : req    in  N     request vector
//                ptr    in  ID_W  highest-priority index
//                gnt    out N     one-hot grant (zero when no request)
//                gnt_id out ID_W  index of the granted request
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  always_comb begin
    int  cand;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    cand   = 0;
    // k is the distance from ptr; the first requester at the smallest
    // distance wins.
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      for (int i = 0; i < N; i++) begin
        if (!found && (i == cand) && req[i]) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          gnt_id = ID_W'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : jk_bank_sequencer
//  Description : Shares one bank of JK flops among several requesters. A
//                round-robin grant selects one request; its bit is driven for
//                one cycle, the resulting Q is sampled and returned.
//  Ports       : clk, rst_n         clock / async active-low reset
//                req_valid/op/idx   per-requester request (packed)
//                req_ready          one-hot grant (accept = valid & ready)
//                jk_j, jk_k         registered J/K drive to the bank
//                bank_q             Q outputs of the bank
//                rsp_valid/id/q/err response (valid is a one-cycle pulse)
//                busy               high whenever the sequencer is not idle
//  Revision    : 1.0  initial release
// ============================================================================
module jk_bank_sequencer
  import jk_pkg::*;
#(
  parameter int N_FF  = 8,
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_FF),
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [IDX_W*N_REQ-1:0] req_idx,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_FF-1:0]        jk_j,
  output logic [N_FF-1:0]        jk_k,
  input  logic [N_FF-1:0]        bank_q,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_q,
  output logic                   rsp_err,
  output logic                   busy
);

  state_t            state_q,  state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q,     id_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic              err_q,    err_d;
  logic [N_FF-1:0]   jk_j_q,   jk_j_d;
  logic [N_FF-1:0]   jk_k_q,   jk_k_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic              rsp_q_q,     rsp_q_d;
  logic              rsp_err_q,   rsp_err_d;

  logic [1:0]        op_arr  [N_REQ];
  logic [IDX_W-1:0]  idx_arr [N_REQ];
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_arr[g]  = req_op[2*g +: 2];
    assign idx_arr[g] = req_idx[IDX_W*g +: IDX_W];
  end

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;

  always_comb begin
    logic [1:0] jk_sel;
    logic       hit;
    logic       q_sel;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    idx_d       = idx_q;
    err_d       = err_q;
    jk_j_d      = '0;
    jk_k_d      = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_q_d     = rsp_q_q;
    rsp_err_d   = rsp_err_q;
    jk_sel      = op_to_jk(op_arr[gnt_id]);
    hit         = 1'b0;
    q_sel       = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Reset leaves jk_k at zero, so the first INIT edge loads the clear
        // pattern; once it has been presented for a cycle, move on.
        if (jk_k_q == '1) begin
          state_d = ST_IDLE;
        end else begin
          jk_k_d = '1;
        end
      end
      ST_IDLE: begin
        if (|req_ready) begin
          id_d     = gnt_id;
          idx_d    = idx_arr[gnt_id];
          rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
          // The drive is registered here so it is visible during DRIVE. An
          // index that matches no flop leaves the bank untouched.
          for (int b = 0; b < N_FF; b++) begin
            if (idx_arr[gnt_id] == IDX_W'(b)) begin
              hit       = 1'b1;
              jk_j_d[b] = jk_sel[1];
              jk_k_d[b] = jk_sel[0];
            end
          end
          err_d   = ~hit;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        for (int b = 0; b < N_FF; b++) begin
          if (idx_q == IDX_W'(b)) q_sel = bank_q[b];
        end
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = err_q;
        rsp_q_d     = err_q ? 1'b0 : q_sel;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      jk_j_q      <= '0;
      jk_k_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      jk_j_q      <= jk_j_d;
      jk_k_q      <= jk_k_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_q_q     <= rsp_q_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign jk_j      = jk_j_q;
  assign jk_k      = jk_k_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_bank_sequencer
//  Description : Self-checking bench for jk_bank_sequencer with a behavioural
//                JK bank and a reference model of bank contents and
//                round-robin grant order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jk_bank_sequencer;
  import jk_pkg::*;

  localparam int N_FF  = 8;
  localparam int N_REQ = 4;
  localparam int IDX_W = 4;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [2*N_REQ-1:0]     req_op = '0;
  logic [IDX_W*N_REQ-1:0] req_idx = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [N_FF-1:0]        jk_j, jk_k, bank_q;
  logic                   rsp_valid, rsp_q, rsp_err, busy;
  logic [ID_W-1:0]        rsp_id;

  int checks = 0;
  int errors = 0;

  // Reference model: expected bank contents and round-robin pointer.
  logic [N_FF-1:0] ref_bank;
  int              ref_ptr;

  always #5 clk = ~clk;

  jk_bank_sequencer #(.N_FF(N_FF), .N_REQ(N_REQ), .IDX_W(IDX_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(req_ready), .jk_j(jk_j), .jk_k(jk_k), .bank_q(bank_q),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural JK bank without reset.
  initial bank_q = 8'h5A;
  always @(posedge clk) begin
    for (int b = 0; b < N_FF; b++) begin
      case ({jk_j[b], jk_k[b]})
        2'b01:   bank_q[b] <= 1'b0;
        2'b10:   bank_q[b] <= 1'b1;
        2'b11:   bank_q[b] <= ~bank_q[b];
        default: bank_q[b] <= bank_q[b];
      endcase
    end
  end

  function automatic logic ref_apply(input logic [1:0] op, input int idx);
    if (idx >= N_FF) return 1'b0;
    case (op)
      OP_CLR:    ref_bank[idx] = 1'b0;
      OP_SET:    ref_bank[idx] = 1'b1;
      OP_TOGGLE: ref_bank[idx] = ~ref_bank[idx];
      default:   ref_bank[idx] = ref_bank[idx];
    endcase
    return ref_bank[idx];
  endfunction

  function automatic int ref_grant(input logic [N_REQ-1:0] mask);
    for (int k = 0; k < N_REQ; k++) begin
      if (mask[(ref_ptr + k) % N_REQ]) return (ref_ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Presents one request and waits (bounded) until it is granted; returns in
  // the DRIVE cycle with valid dropped.
  task automatic accept(input int id, input logic [1:0] op, input int idx, output bit ok);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_op[2*id +: 2] = op;
    req_idx[IDX_W*id +: IDX_W] = IDX_W'(idx);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      #1;
      if (req_ready[id]) begin ok = 1'b1; break; end
      cyc();
    end
    cyc();
    req_valid = '0;
    if (ok) ref_ptr = (id + 1) % N_REQ;
  endtask

  task automatic test_reset;
    bit seen;
    req_valid = '0;
    rst_n = 1'b0;
    cyc(); cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h expected 0", req_ready); end
    checks++; if ({jk_j, jk_k} !== 16'h0) begin errors++; $display("FAIL reset_jk: got %h expected 0", {jk_j, jk_k}); end
    checks++; if ({rsp_valid, rsp_id, rsp_q, rsp_err} !== 5'h0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_id, rsp_q, rsp_err}); end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cyc();
      if (jk_k === 8'hFF) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL init_clear: got jk_k=%h expected ff", jk_k); end
    checks++; if (jk_j !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL init_cycle: got jk_j=%h busy=%b expected 00 1", jk_j, busy); end
    cyc();
    checks++; if (busy !== 1'b0 || jk_k !== 8'h00) begin errors++; $display("FAIL init_done: got busy=%b jk_k=%h expected 0 00", busy, jk_k); end
    checks++; if (bank_q !== 8'h00) begin errors++; $display("FAIL init_bank: got %h expected 00", bank_q); end
    ref_bank = '0;
    ref_ptr = 0;
  endtask

  task automatic test_set;
    bit ok; logic exp_q;
    accept(0, OP_SET, 3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL set_accept: got no grant expected grant 0"); end
    exp_q = ref_apply(OP_SET, 3);
    checks++; if (jk_j !== 8'h08 || jk_k !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL set_drive: got j=%h k=%h busy=%b expected 08 00 1", jk_j, jk_k, busy); end
    cyc();
    checks++; if ({jk_j, jk_k} !== 16'h0) begin errors++; $display("FAIL set_sample_jk: got %h expected 0", {jk_j, jk_k}); end
    cyc();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_q !== exp_q || rsp_err !== 1'b0) begin errors++; $display("FAIL set_rsp: got v=%b id=%0d q=%b err=%b expected 1 0 %b 0", rsp_valid, rsp_id, rsp_q, rsp_err, exp_q); end
    checks++; if (bank_q !== ref_bank) begin errors++; $display("FAIL set_bank: got %h expected %h", bank_q, ref_bank); end
    cyc();
    checks++; if (rsp_valid !== 1'b0 || rsp_q !== exp_q) begin errors++; $display("FAIL set_hold: got v=%b q=%b expected 0 %b", rsp_valid, rsp_q, exp_q); end
  endtask

  task automatic test_back_to_back;
    bit ok; logic exp0, exp1;
    accept(1, OP_TOGGLE, 3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept: got no grant expected grant 1"); end
    exp0 = ref_apply(OP_TOGGLE, 3);
    req_valid[1] = 1'b1;
    #1;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL b2b_drive_ready: got %h expected 0", req_ready); end
    cyc(); #1;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL b2b_sample_ready: got %h expected 0", req_ready); end
    cyc(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_q !== exp0 || rsp_id !== 2'd1) begin errors++; $display("FAIL b2b_rsp0: got v=%b q=%b id=%0d expected 1 %b 1", rsp_valid, rsp_q, rsp_id, exp0); end
    checks++; if (req_ready !== 4'h2) begin errors++; $display("FAIL b2b_second_grant: got %h expected 2", req_ready); end
    exp1 = ref_apply(OP_TOGGLE, 3);
    ref_ptr = 2;
    cyc();
    req_valid = '0;
    checks++; if (jk_j !== 8'h08 || jk_k !== 8'h08) begin errors++; $display("FAIL b2b_drive2: got j=%h k=%h expected 08 08", jk_j, jk_k); end
    cyc(); cyc(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_q !== exp1 || rsp_id !== 2'd1) begin errors++; $display("FAIL b2b_rsp1: got v=%b q=%b id=%0d expected 1 %b 1", rsp_valid, rsp_q, rsp_id, exp1); end
  endtask

  task automatic test_round_robin;
    int exp_id, idx; logic [1:0] op; logic exp_q;
    test_reset();
    for (int i = 0; i < N_REQ; i++) begin
      req_op[2*i +: 2] = 2'($urandom_range(0, 3));
      req_idx[IDX_W*i +: IDX_W] = IDX_W'($urandom_range(0, N_FF - 1));
    end
    req_valid = '1;
    #1;
    for (int g = 0; g < 8; g++) begin
      exp_id = ref_grant(req_valid);
      checks++; if (req_ready !== 4'(1 << exp_id)) begin errors++; $display("FAIL rr_grant%0d: got %h expected %h", g, req_ready, 4'(1 << exp_id)); end
      op = req_op[2*exp_id +: 2];
      idx = int'(req_idx[IDX_W*exp_id +: IDX_W]);
      exp_q = ref_apply(op, idx);
      ref_ptr = (exp_id + 1) % N_REQ;
      cyc();
      req_op[2*exp_id +: 2] = 2'($urandom_range(0, 3));
      req_idx[IDX_W*exp_id +: IDX_W] = IDX_W'($urandom_range(0, N_FF - 1));
      #1;
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rr_busy_ready%0d: got %h expected 0", g, req_ready); end
      cyc(); cyc(); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_q !== exp_q) begin errors++; $display("FAIL rr_rsp%0d: got v=%b id=%0d q=%b expected 1 %0d %b", g, rsp_valid, rsp_id, rsp_q, exp_id, exp_q); end
    end
    req_valid = '0;
  endtask

  task automatic test_error;
    bit ok;
    req_valid = '0;
    cyc();
    accept(2, OP_CLR, 9, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_accept: got no grant expected grant 2"); end
    checks++; if ({jk_j, jk_k} !== 16'h0) begin errors++; $display("FAIL err_drive: got %h expected 0", {jk_j, jk_k}); end
    cyc();
    checks++; if ({jk_j, jk_k} !== 16'h0) begin errors++; $display("FAIL err_sample: got %h expected 0", {jk_j, jk_k}); end
    cyc();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_q !== 1'b0 || rsp_id !== 2'd2) begin errors++; $display("FAIL err_rsp: got v=%b err=%b q=%b id=%0d expected 1 1 0 2", rsp_valid, rsp_err, rsp_q, rsp_id); end
    checks++; if (bank_q !== ref_bank) begin errors++; $display("FAIL err_bank: got %h expected %h", bank_q, ref_bank); end
  endtask

  task automatic test_random;
    logic [N_REQ-1:0] mask; int exp_id, idx; logic [1:0] op; logic exp_q, exp_err;
    logic [N_FF-1:0] exp_j, exp_k;
    for (int it = 0; it < 24; it++) begin
      mask = N_REQ'($urandom_range(0, 15));
      for (int i = 0; i < N_REQ; i++) begin
        req_op[2*i +: 2] = 2'($urandom_range(0, 3));
        req_idx[IDX_W*i +: IDX_W] = IDX_W'($urandom_range(0, 9));
      end
      req_valid = mask;
      #1;
      exp_id = ref_grant(mask);
      if (exp_id < 0) begin
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rnd_idle%0d: got %h expected 0", it, req_ready); end
        cyc();
        continue;
      end
      checks++; if (req_ready !== 4'(1 << exp_id)) begin errors++; $display("FAIL rnd_grant%0d: got %h expected %h", it, req_ready, 4'(1 << exp_id)); end
      op = req_op[2*exp_id +: 2];
      idx = int'(req_idx[IDX_W*exp_id +: IDX_W]);
      exp_err = (idx >= N_FF);
      exp_j = '0; exp_k = '0;
      if (!exp_err) begin exp_j[idx] = op[1]; exp_k[idx] = op[0]; end
      exp_q = ref_apply(op, idx);
      ref_ptr = (exp_id + 1) % N_REQ;
      cyc();
      req_valid = '0;
      checks++; if (jk_j !== exp_j || jk_k !== exp_k) begin errors++; $display("FAIL rnd_drive%0d: got j=%h k=%h expected %h %h", it, jk_j, jk_k, exp_j, exp_k); end
      cyc(); cyc(); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_q !== exp_q || rsp_err !== exp_err) begin errors++; $display("FAIL rnd_rsp%0d: got v=%b id=%0d q=%b err=%b expected 1 %0d %b %b", it, rsp_valid, rsp_id, rsp_q, rsp_err, exp_id, exp_q, exp_err); end
      checks++; if (bank_q !== ref_bank) begin errors++; $display("FAIL rnd_bank%0d: got %h expected %h", it, bank_q, ref_bank); end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_op;
    bit ok, seen;
    cyc();
    accept(0, OP_SET, 5, ok);
    checks++; if (!ok || jk_j !== 8'h20) begin errors++; $display("FAIL mid_drive: got ok=%b j=%h expected 1 20", ok, jk_j); end
    rst_n = 1'b0;
    #1;
    checks++; if ({jk_j, jk_k} !== 16'h0 || busy !== 1'b1) begin errors++; $display("FAIL mid_abort: got jk=%h busy=%b expected 0 1", {jk_j, jk_k}, busy); end
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    rst_n = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cyc();
      if (rsp_valid !== 1'b0) seen = 1'b1;
      if (jk_k === 8'hFF) begin ok = 1'b1; break; end
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_no_rsp: got rsp_valid=1 expected 0"); end
    checks++; if (!ok) begin errors++; $display("FAIL mid_reinit: got jk_k=%h expected ff", jk_k); end
    cyc();
    checks++; if (busy !== 1'b0 || bank_q !== 8'h00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_idle: got busy=%b bank=%h v=%b expected 0 00 0", busy, bank_q, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_back_to_back();
    test_round_robin();
    test_error();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
